// File: rtl/tcdm_bank_responder.sv
// Purpose : TCDM slave-side responder; word-interleaved multi-bank SRAM with per-bank round-robin grant.
// Latency : grant combinational in the request cycle; r_valid/r_data exactly one cycle after each grant.
// Backpr. : grant back-pressure via bank contention, stall_i and clear_i; responses cannot be stalled.
//
// Ports:
//   clk_i, rst_ni, clear_i   clock, async active-low reset, synchronous soft clear
//   tcdm_req/add/wen/be/data per-port request fields (wen=1 read, wen=0 write)
//   tcdm_gnt                 per-port grant, combinational from the request
//   tcdm_r_valid/r_data      per-port registered response
//   stall_i                  per-port grant inhibit
module tcdm_bank_responder #(
    parameter int unsigned NB_PORTS   = 6,
    parameter int unsigned NB_BANKS   = 4,
    parameter int unsigned BANK_WORDS = 256
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic                      clear_i,
    input  logic [NB_PORTS-1:0]       tcdm_req,
    output logic [NB_PORTS-1:0]       tcdm_gnt,
    input  logic [NB_PORTS-1:0][31:0] tcdm_add,
    input  logic [NB_PORTS-1:0]       tcdm_wen,
    input  logic [NB_PORTS-1:0][3:0]  tcdm_be,
    input  logic [NB_PORTS-1:0][31:0] tcdm_data,
    output logic [NB_PORTS-1:0][31:0] tcdm_r_data,
    output logic [NB_PORTS-1:0]       tcdm_r_valid,
    input  logic [NB_PORTS-1:0]       stall_i
);

    localparam int unsigned BANK_BITS = $clog2(NB_BANKS);
    localparam int unsigned ROW_BITS  = $clog2(BANK_WORDS);
    localparam int unsigned PORT_BITS = (NB_PORTS > 1) ? $clog2(NB_PORTS) : 1;
    localparam int unsigned ROW_LSB   = 2 + BANK_BITS;

    typedef logic [BANK_BITS-1:0] bank_idx_t;
    typedef logic [ROW_BITS-1:0]  row_idx_t;
    typedef logic [PORT_BITS-1:0] port_idx_t;

    // ------------------------------------------------------------------
    // Address decode. Byte offset and bits above the array are dropped,
    // so out-of-range addresses alias modulo the total size.
    // ------------------------------------------------------------------
    bank_idx_t [NB_PORTS-1:0] port_bank;
    row_idx_t  [NB_PORTS-1:0] port_row;

    always_comb begin
        for (int p = 0; p < NB_PORTS; p++) begin
            port_bank[p] = tcdm_add[p][2 +: BANK_BITS];
            port_row[p]  = tcdm_add[p][ROW_LSB +: ROW_BITS];
        end
    end

    logic unused_add;
    assign unused_add = ^tcdm_add;

    // ------------------------------------------------------------------
    // Per-bank round-robin arbitration
    // ------------------------------------------------------------------
    logic                                arb_en;
    logic [NB_BANKS-1:0][NB_PORTS-1:0]   bank_cand;
    logic [NB_BANKS-1:0]                 bank_gnt_vld;
    port_idx_t [NB_BANKS-1:0]            bank_gnt_idx;
    port_idx_t [NB_BANKS-1:0]            rr_ptr_q;
    logic [PORT_BITS:0]                  scan_sum;
    port_idx_t                           scan_idx;
    logic [NB_PORTS-1:0]                 gnt;

    // Reset and clear both suppress every grant, so neither the memory nor
    // the response registers can see a transaction while they are active.
    assign arb_en = rst_ni & ~clear_i;

    always_comb begin
        for (int b = 0; b < NB_BANKS; b++) begin
            for (int p = 0; p < NB_PORTS; p++) begin
                bank_cand[b][p] = arb_en & tcdm_req[p] & ~stall_i[p] &
                                  (port_bank[p] == BANK_BITS'(b));
            end
        end
    end

    // Scan upward from the bank pointer with wrap; first candidate wins.
    always_comb begin
        scan_sum     = '0;
        scan_idx     = '0;
        bank_gnt_vld = '0;
        bank_gnt_idx = '0;
        for (int b = 0; b < NB_BANKS; b++) begin
            for (int i = 0; i < NB_PORTS; i++) begin
                scan_sum = {1'b0, rr_ptr_q[b]} + (PORT_BITS+1)'(i);
                if (scan_sum >= (PORT_BITS+1)'(NB_PORTS)) begin
                    scan_sum = scan_sum - (PORT_BITS+1)'(NB_PORTS);
                end
                scan_idx = scan_sum[PORT_BITS-1:0];
                if (!bank_gnt_vld[b] && bank_cand[b][scan_idx]) begin
                    bank_gnt_vld[b] = 1'b1;
                    bank_gnt_idx[b] = scan_idx;
                end
            end
        end
    end

    always_comb begin
        gnt = '0;
        for (int p = 0; p < NB_PORTS; p++) begin
            for (int b = 0; b < NB_BANKS; b++) begin
                if (bank_gnt_vld[b] && (bank_gnt_idx[b] == PORT_BITS'(p))) begin
                    gnt[p] = 1'b1;
                end
            end
        end
    end

    assign tcdm_gnt = gnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_ptr_q <= '0;
        end else if (clear_i) begin
            rr_ptr_q <= '0;
        end else begin
            for (int b = 0; b < NB_BANKS; b++) begin
                if (bank_gnt_vld[b]) begin
                    rr_ptr_q[b] <= (bank_gnt_idx[b] == PORT_BITS'(NB_PORTS - 1)) ?
                                   '0 : bank_gnt_idx[b] + 1'b1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Bank arrays: one access per bank per cycle, steered by the winner
    // ------------------------------------------------------------------
    logic [NB_BANKS-1:0]         bank_we;
    logic [NB_BANKS-1:0]         bank_re;
    row_idx_t [NB_BANKS-1:0]     bank_row;
    logic [NB_BANKS-1:0][3:0]    bank_be;
    logic [NB_BANKS-1:0][31:0]   bank_wdata;
    logic [NB_BANKS-1:0][31:0]   bank_rdata_q;
    logic [31:0]                 mem_q [NB_BANKS][BANK_WORDS];

    always_comb begin
        for (int b = 0; b < NB_BANKS; b++) begin
            bank_we[b]    = bank_gnt_vld[b] & ~tcdm_wen[bank_gnt_idx[b]];
            bank_re[b]    = bank_gnt_vld[b] &  tcdm_wen[bank_gnt_idx[b]];
            bank_row[b]   = port_row[bank_gnt_idx[b]];
            bank_be[b]    = tcdm_be[bank_gnt_idx[b]];
            bank_wdata[b] = tcdm_data[bank_gnt_idx[b]];
        end
    end

    // Memory is deliberately not reset. A bank serves either a read or a
    // write in one cycle, so the read register never sees a same-cycle write.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NB_BANKS; b++) begin
            if (bank_we[b]) begin
                for (int k = 0; k < 4; k++) begin
                    if (bank_be[b][k]) begin
                        mem_q[b][bank_row[b]][8*k +: 8] <= bank_wdata[b][8*k +: 8];
                    end
                end
            end
            if (bank_re[b]) begin
                bank_rdata_q[b] <= mem_q[b][bank_row[b]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-port response: remember which bank served the port and whether
    // it was a read; r_data holds the last response once r_valid drops.
    // ------------------------------------------------------------------
    logic [NB_PORTS-1:0]         rvld_q;
    logic [NB_PORTS-1:0]         is_rd_q;
    bank_idx_t [NB_PORTS-1:0]    rsp_bank_q;
    logic [NB_PORTS-1:0][31:0]   rdata_hold_q;
    logic [NB_PORTS-1:0][31:0]   rsp_dat;

    always_comb begin
        for (int p = 0; p < NB_PORTS; p++) begin
            rsp_dat[p]     = is_rd_q[p] ? bank_rdata_q[rsp_bank_q[p]] : 32'h0;
            tcdm_r_data[p] = rvld_q[p] ? rsp_dat[p] : rdata_hold_q[p];
        end
    end

    assign tcdm_r_valid = rvld_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rvld_q       <= '0;
            is_rd_q      <= '0;
            rsp_bank_q   <= '0;
            rdata_hold_q <= '0;
        end else begin
            rvld_q <= gnt;
            for (int p = 0; p < NB_PORTS; p++) begin
                if (gnt[p]) begin
                    is_rd_q[p]    <= tcdm_wen[p];
                    rsp_bank_q[p] <= port_bank[p];
                end
                if (rvld_q[p]) begin
                    rdata_hold_q[p] <= rsp_dat[p];
                end
            end
        end
    end

endmodule

// File: tb/tb_tcdm_bank_responder.sv
// Purpose : directed bench for tcdm_bank_responder with hand-computed expectations.
// Latency : inputs driven 1ns after the rising edge, outputs sampled 1ns later.
// Backpr. : exercises contention, stall_i, clear_i and async reset.
module tb_tcdm_bank_responder;

    localparam int NP = 6;

    logic                clk_i = 1'b0;
    logic                rst_ni;
    logic                clear_i;
    logic [NP-1:0]       req, gnt, wen, rvld, stall;
    logic [NP-1:0][31:0] add, wdat, rdat;
    logic [NP-1:0][3:0]  be;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk_i = ~clk_i;

    tcdm_bank_responder #(.NB_PORTS(NP), .NB_BANKS(4), .BANK_WORDS(256)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .clear_i     (clear_i),
        .tcdm_req    (req),
        .tcdm_gnt    (gnt),
        .tcdm_add    (add),
        .tcdm_wen    (wen),
        .tcdm_be     (be),
        .tcdm_data   (wdat),
        .tcdm_r_data (rdat),
        .tcdm_r_valid(rvld),
        .stall_i     (stall)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        req  = '0;
        wen  = '1;
        add  = '0;
        wdat = '0;
        be   = '0;
    endtask

    task automatic rd(input int p, input logic [31:0] a);
        req[p] = 1'b1; wen[p] = 1'b1; add[p] = a; be[p] = 4'hF; wdat[p] = '0;
    endtask

    task automatic wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
        req[p] = 1'b1; wen[p] = 1'b0; add[p] = a; be[p] = b; wdat[p] = d;
    endtask

    initial begin
        rst_ni  = 1'b0;
        clear_i = 1'b0;
        stall   = '0;
        idle();
        rd(0, 32'h0);
        #1;
        // reset state: grant suppressed even with a request pending
        check("rst_gnt",   32'(gnt),  32'h0);
        check("rst_rvld",  32'(rvld), 32'h0);
        check("rst_rdata", rdat[0],   32'h0);
        step(); step();
        rst_ni = 1'b1;
        idle();

        // single write then read on bank 0
        step();
        wr(0, 32'h0, 32'hDEADBEEF, 4'hF); #1;
        check("wr_gnt", 32'(gnt[0]), 32'h1);
        step();
        idle(); rd(0, 32'h0); #1;
        check("wr_rvld",  32'(rvld[0]), 32'h1);
        check("wr_rdata", rdat[0],       32'h0);
        check("rd_gnt",   32'(gnt[0]),   32'h1);
        step();
        idle(); #1;
        check("rd_rvld",  32'(rvld[0]), 32'h1);
        check("rd_rdata", rdat[0],      32'hDEADBEEF);
        step();
        check("idle_rvld", 32'(rvld[0]), 32'h0);
        check("idle_hold", rdat[0],      32'hDEADBEEF);

        // byte enables
        wr(0, 32'h10, 32'h11223344, 4'hF);
        step();
        wr(0, 32'h10, 32'hAABBCCDD, 4'b0101);
        step();
        rd(0, 32'h10);
        step();
        idle(); #1;
        check("be_rdata", rdat[0], 32'h11BB33DD);

        // seed 0x4 from port 3 (moves bank 1 pointer to 4), then contention
        wr(3, 32'h4, 32'hCAFEF00D, 4'hF);
        step();
        idle(); rd(0, 32'h4); rd(1, 32'h4); rd(2, 32'h4); #1;
        check("cont_gnt0", 32'(gnt), 32'h01);
        step();
        check("cont_gnt1",  32'(gnt),  32'h02);
        check("cont_rvld0", 32'(rvld), 32'h01);
        step();
        check("cont_gnt2",  32'(gnt),  32'h04);
        check("cont_rvld1", 32'(rvld), 32'h02);
        check("cont_data1", rdat[1],   32'hCAFEF00D);
        step();
        idle(); #1;
        check("cont_rvld2", 32'(rvld), 32'h04);
        check("cont_data2", rdat[2],   32'hCAFEF00D);

        // four banks in parallel
        step();
        rd(0, 32'h0); rd(1, 32'h4); rd(2, 32'h8); rd(3, 32'hC); #1;
        check("par_gnt", 32'(gnt), 32'h0F);
        step();
        idle(); #1;
        check("par_rvld",  32'(rvld), 32'h0F);
        check("par_data0", rdat[0],   32'hDEADBEEF);
        check("par_data1", rdat[1],   32'hCAFEF00D);

        // stall for three cycles with an aliased address
        step();
        stall[0] = 1'b1;
        rd(0, 32'h1000);
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_gnt",  32'(gnt[0]),  32'h0);
            check("stall_rvld", 32'(rvld[0]), 32'h0);
            step();
        end
        stall[0] = 1'b0; #1;
        check("unstall_gnt", 32'(gnt[0]), 32'h1);
        step();
        idle(); #1;
        check("wrap_rvld", 32'(rvld[0]), 32'h1);
        check("wrap_data", rdat[0],      32'hDEADBEEF);

        // clear: port 4 write moves bank 2 pointer to 5, clear returns it to 0
        step();
        wr(4, 32'h8, 32'h0BADF00D, 4'hF);
        step();
        idle(); clear_i = 1'b1; rd(1, 32'h8); #1;
        check("clr_gnt",  32'(gnt),     32'h0);
        check("clr_hold", rdat[1],      32'hCAFEF00D);
        step();
        clear_i = 1'b0; rd(5, 32'h8); #1;
        check("clr_no_rvld", 32'(rvld), 32'h0);
        check("clr_rr_gnt",  32'(gnt),  32'h02);
        step();
        idle(); #1;
        check("clr_rvld", 32'(rvld), 32'h02);
        check("clr_data", rdat[1],   32'h0BADF00D);

        // asynchronous reset with a response in flight
        step();
        rd(0, 32'h0);
        step();
        check("pre_rst_rvld", 32'(rvld[0]), 32'h1);
        check("pre_rst_data", rdat[0],      32'hDEADBEEF);
        #1 rst_ni = 1'b0;
        #1;
        check("arst_rvld", 32'(rvld), 32'h0);
        check("arst_data", rdat[0],   32'h0);
        check("arst_gnt",  32'(gnt),  32'h0);
        step();
        rst_ni = 1'b1;
        idle();
        step();
        check("post_rst_rvld", 32'(rvld), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
